// File: rtl/hazard_ctrl.sv
// Hazard control for the D/X/M/W integer pipeline.
// Tracks the destination register of each in-flight instruction.
// Drives stall, bubble and flush controls, the registered X-stage forwarding selects,
// and two saturating debug counters.
module hazard_ctrl #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 d_valid_i,
    input  logic [4:0]           d_rs1_addr_i,
    input  logic                 d_rs1_used_i,
    input  logic [4:0]           d_rs2_addr_i,
    input  logic                 d_rs2_used_i,
    input  logic [4:0]           d_rd_addr_i,
    input  logic                 d_rd_wen_i,
    input  logic                 d_is_load_i,
    input  logic                 x_branch_taken_i,
    input  logic                 dm_ready_i,
    output logic                 f_stall_o,
    output logic                 d_stall_o,
    output logic                 x_bubble_o,
    output logic                 d_flush_o,
    output logic                 mw_stall_o,
    output logic [1:0]           x_op1_fwd_o,
    output logic [1:0]           x_op2_fwd_o,
    output logic                 w_rd_wen_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o
);

    localparam int unsigned RW = 5;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b01;
    localparam logic [1:0] FWD_W  = 2'b10;

    // Stage records: {valid, rd, wen, load}
    logic          x_valid, m_valid, w_valid;
    logic [RW-1:0] x_rd, m_rd, w_rd;
    logic          x_wen, m_wen, w_wen;
    logic          x_load, m_load, w_load;

    logic x_ewen, m_ewen, w_ewen;
    logic mem_wait, flush, load_use, bubble;
    logic rs1_hit_x, rs2_hit_x;
    logic [1:0] op1_fwd_nxt, op2_fwd_nxt;

    // Effective write enables; r0 never counts as a producer
    assign x_ewen = x_valid & x_wen & (x_rd != '0);
    assign m_ewen = m_valid & m_wen & (m_rd != '0);
    assign w_ewen = w_valid & w_wen & (w_rd != '0);

    assign rs1_hit_x = d_rs1_used_i & (d_rs1_addr_i == x_rd);
    assign rs2_hit_x = d_rs2_used_i & (d_rs2_addr_i == x_rd);

    // Hazard detection in priority order: memory wait, branch flush, load-use
    always_comb begin
        mem_wait = m_valid & m_load & ~dm_ready_i;
        flush    = x_branch_taken_i & ~mem_wait;
        load_use = x_load & x_ewen & d_valid_i & (rs1_hit_x | rs2_hit_x) & ~mem_wait & ~flush;
        bubble   = flush | load_use;
    end

    assign f_stall_o  = mem_wait | load_use;
    assign d_stall_o  = mem_wait | load_use;
    assign x_bubble_o = bubble;
    assign d_flush_o  = flush;
    assign mw_stall_o = mem_wait;
    // W is replayed as a bubble while memory is waiting
    assign w_rd_wen_o = w_ewen & ~mem_wait;

    // Forwarding selects for the instruction about to enter X
    always_comb begin
        op1_fwd_nxt = FWD_RF;
        op2_fwd_nxt = FWD_RF;
        if (d_valid_i && d_rs1_used_i) begin
            if (x_ewen && !x_load && d_rs1_addr_i == x_rd)
                op1_fwd_nxt = FWD_M;
            else if (m_ewen && d_rs1_addr_i == m_rd)
                op1_fwd_nxt = FWD_W;
        end
        if (d_valid_i && d_rs2_used_i) begin
            if (x_ewen && !x_load && d_rs2_addr_i == x_rd)
                op2_fwd_nxt = FWD_M;
            else if (m_ewen && d_rs2_addr_i == m_rd)
                op2_fwd_nxt = FWD_W;
        end
    end

    // Stage record advance and forwarding-select register; everything holds on memory wait
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_valid     <= 1'b0;
            x_rd        <= '0;
            x_wen       <= 1'b0;
            x_load      <= 1'b0;
            m_valid     <= 1'b0;
            m_rd        <= '0;
            m_wen       <= 1'b0;
            m_load      <= 1'b0;
            w_valid     <= 1'b0;
            w_rd        <= '0;
            w_wen       <= 1'b0;
            w_load      <= 1'b0;
            x_op1_fwd_o <= FWD_RF;
            x_op2_fwd_o <= FWD_RF;
        end else if (!mem_wait) begin
            w_valid     <= m_valid;
            w_rd        <= m_rd;
            w_wen       <= m_wen;
            w_load      <= m_load;
            m_valid     <= x_valid;
            m_rd        <= x_rd;
            m_wen       <= x_wen;
            m_load      <= x_load;
            x_valid     <= d_valid_i & ~bubble;
            x_rd        <= d_rd_addr_i;
            x_wen       <= d_rd_wen_i;
            x_load      <= d_is_load_i;
            x_op1_fwd_o <= bubble ? FWD_RF : op1_fwd_nxt;
            x_op2_fwd_o <= bubble ? FWD_RF : op2_fwd_nxt;
        end
    end

    // Saturating stall/flush event counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (f_stall_o && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(1);
            if (d_flush_o && flush_cnt_o != '1)
                flush_cnt_o <= flush_cnt_o + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl.
// The stimulus process queues the expected outputs for each cycle.
// A monitor pops one entry per cycle on the falling edge and compares it.
module tb_hazard_ctrl;

    localparam int unsigned CW = 4;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       wen;
        logic       ld;
    } d_t;

    typedef struct packed {
        logic          chk;
        logic [4:0]    hz;   // {f_stall, d_stall, x_bubble, d_flush, mw_stall}
        logic [1:0]    f1;
        logic [1:0]    f2;
        logic          ww;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    localparam logic [4:0] H0  = 5'b00000;
    localparam logic [4:0] HMW = 5'b11001;
    localparam logic [4:0] HLU = 5'b11100;
    localparam logic [4:0] HFL = 5'b00110;

    logic          clk;
    logic          rst;
    d_t            d;
    logic          br;
    logic          rdy;
    logic          f_stall, d_stall, x_bubble, d_flush, mw_stall, w_rd_wen;
    logic [1:0]    op1_fwd, op2_fwd;
    logic [CW-1:0] stall_cnt, flush_cnt;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    hazard_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .d_valid_i        (d.v),
        .d_rs1_addr_i     (d.rs1),
        .d_rs1_used_i     (d.u1),
        .d_rs2_addr_i     (d.rs2),
        .d_rs2_used_i     (d.u2),
        .d_rd_addr_i      (d.rd),
        .d_rd_wen_i       (d.wen),
        .d_is_load_i      (d.ld),
        .x_branch_taken_i (br),
        .dm_ready_i       (rdy),
        .f_stall_o        (f_stall),
        .d_stall_o        (d_stall),
        .x_bubble_o       (x_bubble),
        .d_flush_o        (d_flush),
        .mw_stall_o       (mw_stall),
        .x_op1_fwd_o      (op1_fwd),
        .x_op2_fwd_o      (op2_fwd),
        .w_rd_wen_o       (w_rd_wen),
        .stall_cnt_o      (stall_cnt),
        .flush_cnt_o      (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic d_t nop();
        return '0;
    endfunction

    function automatic d_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        d_t r;
        r = '0;
        r.v = 1'b1; r.rd = rd; r.wen = 1'b1;
        r.rs1 = rs1; r.u1 = 1'b1; r.rs2 = rs2; r.u2 = 1'b1;
        return r;
    endfunction

    function automatic d_t imm(input logic [4:0] rd, input logic [4:0] rs1);
        d_t r;
        r = '0;
        r.v = 1'b1; r.rd = rd; r.wen = 1'b1; r.rs1 = rs1; r.u1 = 1'b1;
        return r;
    endfunction

    function automatic d_t lw(input logic [4:0] rd, input logic [4:0] rs1);
        d_t r;
        r = imm(rd, rs1);
        r.ld = 1'b1;
        return r;
    endfunction

    // One clock of stimulus plus its expected response
    task automatic cyc(input d_t di, input logic bi, input logic ri, input logic [4:0] hz,
                       input logic [1:0] f1, input logic [1:0] f2, input logic ww,
                       input int sc, input int fc);
        exp_t e;
        @(posedge clk);
        #1;
        rst = 1'b0; d = di; br = bi; rdy = ri;
        e.chk = 1'b1; e.hz = hz; e.f1 = f1; e.f2 = f2; e.ww = ww;
        e.sc = CW'(sc); e.fc = CW'(fc);
        q.push_back(e);
    endtask

    // One reset clock; chk selects whether the all-zero state is checked
    task automatic rcyc(input logic chk);
        exp_t e;
        @(posedge clk);
        #1;
        rst = 1'b1; d = nop(); br = 1'b0; rdy = 1'b1;
        e = '0;
        e.chk = chk;
        q.push_back(e);
    endtask

    // Monitor: compare one queued expectation per cycle
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk) begin
                    a.chk = 1'b1;
                    a.hz  = {f_stall, d_stall, x_bubble, d_flush, mw_stall};
                    a.f1  = op1_fwd;
                    a.f2  = op2_fwd;
                    a.ww  = w_rd_wen;
                    a.sc  = stall_cnt;
                    a.fc  = flush_cnt;
                    checks++;
                    if (a !== e) begin
                        errors++;
                        $display("FAIL cycle_check#%0d t=%0t got hz=%b f1=%b f2=%b ww=%b sc=%0d fc=%0d want hz=%b f1=%b f2=%b ww=%b sc=%0d fc=%0d",
                                 checks, $time, a.hz, a.f1, a.f2, a.ww, a.sc, a.fc,
                                 e.hz, e.f1, e.f2, e.ww, e.sc, e.fc);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1; d = nop(); br = 1'b0; rdy = 1'b1;
        rcyc(1'b0);
        rcyc(1'b1);

        // Back-to-back ALU dependency
        cyc(alu(5, 1, 2), 0, 1, H0, 0, 0, 0, 0, 0);
        cyc(alu(6, 5, 7), 0, 1, H0, 0, 0, 0, 0, 0);
        cyc(nop(),        0, 1, H0, 1, 0, 0, 0, 0);
        cyc(nop(),        0, 1, H0, 0, 0, 1, 0, 0);
        cyc(nop(),        0, 1, H0, 0, 0, 1, 0, 0);
        cyc(nop(),        0, 1, H0, 0, 0, 0, 0, 0);

        // Distance-2 dependency, r0 writer in flight, r0 sources
        cyc(alu(5, 1, 2), 0, 1, H0, 0, 0, 0, 0, 0);
        cyc(imm(0, 1),    0, 1, H0, 0, 0, 0, 0, 0);
        cyc(alu(8, 5, 5), 0, 1, H0, 0, 0, 0, 0, 0);
        cyc(alu(9, 0, 0), 0, 1, H0, 2, 2, 1, 0, 0);
        cyc(nop(),        0, 1, H0, 0, 0, 0, 0, 0);
        cyc(nop(),        0, 1, H0, 0, 0, 1, 0, 0);
        cyc(nop(),        0, 1, H0, 0, 0, 1, 0, 0);
        cyc(nop(),        0, 1, H0, 0, 0, 0, 0, 0);

        // Load-use with data ready
        cyc(lw(3, 2),     0, 1, H0,  0, 0, 0, 0, 0);
        cyc(alu(4, 3, 1), 0, 1, HLU, 0, 0, 0, 0, 0);
        cyc(alu(4, 3, 1), 0, 1, H0,  0, 0, 0, 1, 0);
        cyc(nop(),        0, 1, H0,  2, 0, 1, 1, 0);
        cyc(nop(),        0, 1, H0,  0, 0, 0, 1, 0);
        cyc(nop(),        0, 1, H0,  0, 0, 1, 1, 0);
        cyc(nop(),        0, 1, H0,  0, 0, 0, 1, 0);

        // Slow load: three wait cycles with a valid W held back
        cyc(alu(9, 1, 2),     0, 1, H0,  0, 0, 0, 1, 0);
        cyc(lw(10, 2),        0, 1, H0,  0, 0, 0, 1, 0);
        cyc(alu(11, 9, 1),    0, 1, H0,  0, 0, 0, 1, 0);
        cyc(alu(12, 11, 10),  0, 0, HMW, 2, 0, 0, 1, 0);
        cyc(alu(12, 11, 10),  0, 0, HMW, 2, 0, 0, 2, 0);
        cyc(alu(12, 11, 10),  0, 0, HMW, 2, 0, 0, 3, 0);
        cyc(alu(12, 11, 10),  0, 1, H0,  2, 0, 1, 4, 0);
        cyc(nop(),            0, 1, H0,  1, 2, 1, 4, 0);
        cyc(nop(),            0, 1, H0,  0, 0, 1, 4, 0);
        cyc(nop(),            0, 1, H0,  0, 0, 1, 4, 0);
        cyc(nop(),            0, 1, H0,  0, 0, 0, 4, 0);

        // Branch taken while a load waits and a load-use is pending
        cyc(lw(3, 2),     0, 1, H0,  0, 0, 0, 4, 0);
        cyc(lw(5, 1),     0, 1, H0,  0, 0, 0, 4, 0);
        cyc(alu(6, 5, 3), 1, 0, HMW, 0, 0, 0, 4, 0);
        cyc(alu(6, 5, 3), 1, 0, HMW, 0, 0, 0, 5, 0);
        cyc(alu(6, 5, 3), 1, 1, HFL, 0, 0, 0, 6, 0);
        cyc(nop(),        0, 1, H0,  0, 0, 1, 6, 1);
        cyc(nop(),        0, 1, H0,  0, 0, 1, 6, 1);
        cyc(nop(),        0, 1, H0,  0, 0, 0, 6, 1);

        // Stall counter saturation, then reset in the middle of the stall
        cyc(lw(7, 2),     0, 1, H0,  0, 0, 0, 6, 1);
        cyc(nop(),        0, 1, H0,  0, 0, 0, 6, 1);
        for (int k = 0; k < 20; k++) begin
            n = (6 + k > 15) ? 15 : 6 + k;
            cyc(nop(), 0, 0, HMW, 0, 0, 0, n, 1);
        end
        rcyc(1'b0);
        cyc(nop(),        0, 0, H0,  0, 0, 0, 0, 0);
        cyc(nop(),        0, 1, H0,  0, 0, 0, 0, 0);

        n = 0;
        while (q.size() > 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
